// File: rtl/qqspi_cache.sv
// Direct-mapped, word-granular, write-through read cache in front of the qqspi controller.
// Define QQSPI_CACHE_STATS_EN to add the hit_count/miss_count outputs.
module qqspi_cache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [22:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] rdata,
  input  logic        flush,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef QQSPI_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 23 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StLookup, StMemReq, StRelease} state_e;
  state_e state;

  logic [22:0]         req_addr;
  logic [31:0]         req_wdata;
  logic [3:0]          req_wstrb;
  logic                poison;
  logic                wr_hit;
  logic [Lines-1:0]    line_valid;
  logic [TagBits-1:0]  tag_mem  [Lines];
  logic [31:0]         data_mem [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic                  is_read;
  logic                  lookup_hit;
  logic                  mem_done;
  logic                  fill;
  logic                  merge;

  assign idx        = req_addr[INDEX_BITS-1:0];
  assign tag        = req_addr[22:INDEX_BITS];
  assign is_read    = (req_wstrb == 4'b0000);
  assign lookup_hit = line_valid[idx] && (tag_mem[idx] == tag);
  assign mem_done   = (state == StMemReq) && mem_ready;
  // A flush in the completing cycle also suppresses the update.
  assign fill       = mem_done && is_read && !poison && !flush;
  assign merge      = mem_done && !is_read && wr_hit && !poison && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      ready      <= 1'b0;
      rdata      <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      poison     <= 1'b0;
      wr_hit     <= 1'b0;
      line_valid <= '0;
    end else begin
      ready <= 1'b0;
      if (flush && state != StIdle) poison <= 1'b1;
      unique case (state)
        StIdle: begin
          if (valid && !ready) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_wstrb <= wstrb;
            poison    <= 1'b0;
            wr_hit    <= 1'b0;
            state     <= StLookup;
          end
        end
        StLookup: begin
          if (is_read && lookup_hit) begin
            rdata <= data_mem[idx];
            ready <= 1'b1;
            state <= StIdle;
          end else begin
            mem_addr  <= req_addr;
            mem_valid <= 1'b1;
            state     <= StMemReq;
            if (is_read) begin
              mem_wstrb <= 4'b0000;
            end else begin
              mem_wdata <= req_wdata;
              mem_wstrb <= req_wstrb;
              wr_hit    <= lookup_hit;
            end
          end
        end
        StMemReq: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (is_read) rdata <= mem_rdata;
            state <= StRelease;
          end
        end
        StRelease: begin
          // qqspi restarts on valid && !ready, so wait for its ready to fall.
          if (!mem_ready) begin
            ready <= 1'b1;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
      if (flush) begin
        line_valid <= '0;
      end else if (fill) begin
        line_valid[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_rdata;
    end else if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) data_mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

`ifdef QQSPI_CACHE_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == StLookup && is_read && lookup_hit) hit_count <= hit_count + 32'd1;
      if (state == StRelease && !mem_ready && is_read) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qqspi_cache.sv
// Bench for qqspi_cache: directed scenarios plus random traffic against a line-level cache model.
module tb_qqspi_cache;
  localparam int unsigned IB    = 6;
  localparam int unsigned Lines = 1 << IB;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [22:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        ready;
  logic [31:0] rdata;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef QQSPI_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  qqspi_cache #(.INDEX_BITS(IB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .valid     (valid),
    .ready     (ready),
    .rdata     (rdata),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef QQSPI_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // Downstream memory (what the PSRAM holds) and the model's expected memory.
  logic [31:0] psram   [int];
  logic [31:0] exp_mem [int];
  bit              mv [Lines];
  logic [22-IB:0]  mt [Lines];

  bit          stall = 1'b0;
  int          lat_left = 0;
  int          mem_count = 0;
  logic [22:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  function automatic logic [31:0] dflt(input logic [22:0] a);
    return {9'd0, a} * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] rd_psram(input logic [22:0] a);
    if (psram.exists(int'(a))) return psram[int'(a)];
    return dflt(a);
  endfunction

  function automatic logic [31:0] rd_exp(input logic [22:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return dflt(a);
  endfunction

  function automatic bit model_hit(input logic [22:0] a);
    logic [IB-1:0] i;
    i = a[IB-1:0];
    return mv[i] && (mt[i] == a[22:IB]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // qqspi-like responder: random latency, one-cycle ready pulse.
  initial begin
    logic [31:0] w;
    forever begin
      @(posedge clk); #1;
      if (resetn && mem_valid && !mem_ready && !stall) begin
        if (lat_left != 0) begin
          lat_left--;
        end else begin
          mem_count++;
          if (mem_wstrb != 4'b0000) begin
            w = rd_psram(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            psram[int'(mem_addr)] = w;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            last_wstrb = mem_wstrb;
            mem_rdata  = '0;
          end else begin
            mem_rdata = rd_psram(mem_addr);
          end
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_rdata = '0;
          lat_left  = $urandom_range(0, 3);
        end
      end
    end
  end

  // fmode: 0 none, 1 flush together with the request, 2 flush while waiting on memory.
  task automatic op(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws,
                    input int fmode);
    int          cyc;
    int          mc0;
    bit          exp_hit;
    bit          saw_mv;
    logic [31:0] w;
    logic [IB-1:0] i;
    i = a[IB-1:0];
    if (fmode == 1) for (int k = 0; k < Lines; k++) mv[k] = 1'b0;
    exp_hit    = model_hit(a);
    mc0        = mem_count;
    last_waddr = '0;
    last_wdata = '0;
    last_wstrb = '0;
    addr  = a;
    wdata = wd;
    wstrb = ws;
    valid = 1'b1;
    flush = (fmode == 1);
    if (fmode == 2) stall = 1'b1;
    cyc    = 0;
    saw_mv = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      flush = 1'b0;
      if (saw_mv) stall = 1'b0;
      if (fmode == 2 && mem_valid && !saw_mv) begin
        saw_mv = 1'b1;
        flush  = 1'b1;
      end
    end while (!ready && cyc < 200);
    check("done", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    if (ws == 4'b0000) begin
      check("rdata", rdata, rd_exp(a));
      check("mem_reads", 32'(mem_count - mc0), exp_hit ? 32'd0 : 32'd1);
      if (exp_hit) check("hit_latency", 32'(cyc), 32'd2);
      if (!exp_hit && fmode != 2) begin
        mv[i] = 1'b1;
        mt[i] = a[22:IB];
      end
    end else begin
      check("mem_writes", 32'(mem_count - mc0), 32'd1);
      check("waddr", {9'd0, last_waddr}, {9'd0, a});
      check("wstrb", {28'd0, last_wstrb}, {28'd0, ws});
      check("wdata", last_wdata, wd);
      w = rd_exp(a);
      for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      exp_mem[int'(a)] = w;
    end
    if (fmode == 2) for (int k = 0; k < Lines; k++) mv[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [22:0] a;
    logic [3:0]  ws;
    int          fm;
    int          cyc;
    for (int k = 0; k < Lines; k++) begin
      mv[k] = 1'b0;
      mt[k] = '0;
    end
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    psram[32'h40]   = 32'hDEAD_BEEF;
    exp_mem[32'h40] = 32'hDEAD_BEEF;
    op(23'h000040, 32'h0, 4'b0000, 0);            // miss
    op(23'h000040, 32'h0, 4'b0000, 0);            // hit
    op(23'h000040, 32'h0000_AA00, 4'b0010, 0);    // write-through hit merge
    op(23'h000040, 32'h0, 4'b0000, 0);            // hit with merged byte
    check("merged_word", rdata, 32'hDEAD_AAEF);
    op(23'h000081, 32'h1234_5678, 4'b1111, 0);    // write miss, no allocate
    op(23'h000081, 32'h0, 4'b0000, 0);
    op(23'h000005, 32'h0, 4'b0000, 0);            // alias pair
    op(23'h000045, 32'h0, 4'b0000, 0);
    op(23'h000005, 32'h0, 4'b0000, 0);
    op(23'h000010, 32'h0, 4'b0000, 2);            // poisoned by flush
    op(23'h000010, 32'h0, 4'b0000, 0);
    op(23'h000040, 32'h0, 4'b0000, 0);
    op(23'h000045, 32'h0, 4'b0000, 0);
    op(23'h000045, 32'h0, 4'b0000, 1);            // flush concurrent with accept

    for (int n = 0; n < 250; n++) begin
      a  = 23'(($urandom_range(0, 3) << IB) | $urandom_range(0, 7));
      ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      fm = 0;
      case ($urandom_range(0, 19))
        0: fm = 1;
        1: fm = (ws != 4'b0000 || !model_hit(a)) ? 2 : 0;
        default: fm = 0;
      endcase
      op(a, $urandom, ws, fm);
    end

    // Asynchronous reset while a miss is outstanding downstream.
    op(23'h000020, 32'h0, 4'b0000, 0);
    op(23'h000020, 32'h0, 4'b0000, 0);
    stall = 1'b1;
    addr  = 23'h00013C;
    wstrb = 4'b0000;
    valid = 1'b1;
    cyc   = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!mem_valid && cyc < 50);
    check("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    stall = 1'b0;
    for (int k = 0; k < Lines; k++) mv[k] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    op(23'h000020, 32'h0, 4'b0000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
